// File: rtl/regfile_pkg.sv
// Shared widths, the zero-register index and the write-port source tag
// for the MIPS register-file write-port controller.
package regfile_pkg;

  localparam int unsigned RF_DATA_WIDTH = 32;
  localparam int unsigned RF_ADDR_WIDTH = 5;
  localparam int unsigned REG_ZERO      = 0;

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_ALU,
    SRC_LD,
    SRC_DBG
  } wb_src_t;

endpackage

// File: rtl/regfile_wb_fifo.sv
// Load-return queue with a per-entry live bit, squash-by-address and a
// two-address match port used for read-hazard detection.
module regfile_wb_fifo
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = RF_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = RF_ADDR_WIDTH,
  parameter int unsigned DEPTH      = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_push,
  input  logic [ADDR_WIDTH-1:0] i_push_addr,
  input  logic [DATA_WIDTH-1:0] i_push_data,
  input  logic                  i_pop,
  input  logic                  i_sq_en,
  input  logic [ADDR_WIDTH-1:0] i_sq_addr,
  input  logic [ADDR_WIDTH-1:0] i_chk_a,
  input  logic [ADDR_WIDTH-1:0] i_chk_b,
  output logic                  o_empty,
  output logic                  o_full,
  output logic                  o_head_live,
  output logic [ADDR_WIDTH-1:0] o_head_addr,
  output logic [DATA_WIDTH-1:0] o_head_data,
  output logic                  o_match
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [PW:0]           r_wr_ptr;
  logic [PW:0]           r_rd_ptr;
  logic [DEPTH-1:0]      r_live;
  logic [ADDR_WIDTH-1:0] r_addr [DEPTH];
  logic [DATA_WIDTH-1:0] r_data [DEPTH];
  logic [ADDR_WIDTH-1:0] w_zero;

  assign w_zero      = ADDR_WIDTH'(REG_ZERO);
  assign o_empty     = (r_wr_ptr == r_rd_ptr);
  assign o_full      = (r_wr_ptr[PW] != r_rd_ptr[PW]) &&
                       (r_wr_ptr[PW-1:0] == r_rd_ptr[PW-1:0]);
  assign o_head_live = r_live[r_rd_ptr[PW-1:0]];
  assign o_head_addr = r_addr[r_rd_ptr[PW-1:0]];
  assign o_head_data = r_data[r_rd_ptr[PW-1:0]];

  // Later assignments win: pop clears its slot, and a same-cycle push is
  // born dead when the concurrent ALU write targets the same register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_live   <= '0;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (i_sq_en && (r_addr[i] == i_sq_addr)) r_live[i] <= 1'b0;
      end
      if (i_pop) begin
        r_live[r_rd_ptr[PW-1:0]] <= 1'b0;
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (i_push) begin
        r_live[r_wr_ptr[PW-1:0]] <= !(i_sq_en && (i_push_addr == i_sq_addr));
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (i_push) begin
      r_addr[r_wr_ptr[PW-1:0]] <= i_push_addr;
      r_data[r_wr_ptr[PW-1:0]] <= i_push_data;
    end
  end

  always_comb begin
    o_match = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (r_live[i] &&
          (((i_chk_a != w_zero) && (r_addr[i] == i_chk_a)) ||
           ((i_chk_b != w_zero) && (r_addr[i] == i_chk_b))))
        o_match = 1'b1;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port between ALU writeback, queued load
// returns and debug writes, and flags read hazards on pending writes.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = RF_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = RF_ADDR_WIDTH,
  parameter int unsigned FIFO_DEPTH = 2,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  alu_we,
  input  logic [ADDR_WIDTH-1:0] alu_addr,
  input  logic [DATA_WIDTH-1:0] alu_data,
  output logic                  alu_stall,
  input  logic                  ld_valid,
  output logic                  ld_ready,
  input  logic [ADDR_WIDTH-1:0] ld_addr,
  input  logic [DATA_WIDTH-1:0] ld_data,
  input  logic                  dbg_valid,
  output logic                  dbg_ready,
  input  logic [ADDR_WIDTH-1:0] dbg_addr,
  input  logic [DATA_WIDTH-1:0] dbg_data,
  input  logic [ADDR_WIDTH-1:0] chk_addr_a,
  input  logic [ADDR_WIDTH-1:0] chk_addr_b,
  output logic                  stall_rd,
  output logic                  rf_we,
  output logic [ADDR_WIDTH-1:0] rf_waddr,
  output logic [DATA_WIDTH-1:0] rf_wdata
);

  localparam int unsigned CW = $clog2(STARVE_MAX + 1);

  logic                  r_in_reset;
  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_waddr;
  logic [DATA_WIDTH-1:0] r_wdata;
  wb_src_t               r_src;
  logic [CW-1:0]         r_cnt;
  logic                  r_alu_stall;

  logic                  w_zero_ok_alu, w_alu_wr, w_push, w_pop, w_drain, w_dbg_wr;
  logic                  w_empty, w_full, w_head_live, w_match, w_out_match;
  logic [ADDR_WIDTH-1:0] w_head_addr, w_zero;
  logic [DATA_WIDTH-1:0] w_head_data;
  logic [CW-1:0]         w_cnt_next;
  logic                  w_we_next;
  logic [ADDR_WIDTH-1:0] w_waddr_next;
  logic [DATA_WIDTH-1:0] w_wdata_next;
  wb_src_t               w_src_next;

  assign w_zero        = ADDR_WIDTH'(REG_ZERO);
  assign w_zero_ok_alu = (alu_addr != w_zero);
  assign w_alu_wr      = alu_we && w_zero_ok_alu;
  assign ld_ready      = !w_full && !r_in_reset;
  assign w_push        = ld_valid && ld_ready && (ld_addr != w_zero);
  assign w_drain       = !alu_we && !w_empty && w_head_live;
  assign w_pop         = w_drain || (!w_empty && !w_head_live);
  assign dbg_ready     = !alu_we && w_empty && !ld_valid && !r_in_reset;
  assign w_dbg_wr      = dbg_valid && dbg_ready && (dbg_addr != w_zero);

  regfile_wb_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_push      (w_push),
    .i_push_addr (ld_addr),
    .i_push_data (ld_data),
    .i_pop       (w_pop),
    .i_sq_en     (w_alu_wr),
    .i_sq_addr   (alu_addr),
    .i_chk_a     (chk_addr_a),
    .i_chk_b     (chk_addr_b),
    .o_empty     (w_empty),
    .o_full      (w_full),
    .o_head_live (w_head_live),
    .o_head_addr (w_head_addr),
    .o_head_data (w_head_data),
    .o_match     (w_match)
  );

  always_comb begin
    w_we_next    = 1'b0;
    w_waddr_next = r_waddr;
    w_wdata_next = r_wdata;
    w_src_next   = SRC_NONE;
    if (w_alu_wr) begin
      w_we_next    = 1'b1;
      w_waddr_next = alu_addr;
      w_wdata_next = alu_data;
      w_src_next   = SRC_ALU;
    end else if (w_drain) begin
      w_we_next    = 1'b1;
      w_waddr_next = w_head_addr;
      w_wdata_next = w_head_data;
      w_src_next   = SRC_LD;
    end else if (w_dbg_wr) begin
      w_we_next    = 1'b1;
      w_waddr_next = dbg_addr;
      w_wdata_next = dbg_data;
      w_src_next   = SRC_DBG;
    end
  end

  always_comb begin
    w_cnt_next = r_cnt;
    if (w_empty || w_pop)
      w_cnt_next = '0;
    else if (w_head_live && alu_we && (r_cnt != CW'(STARVE_MAX)))
      w_cnt_next = r_cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_in_reset  <= 1'b1;
      r_we        <= 1'b0;
      r_waddr     <= '0;
      r_wdata     <= '0;
      r_src       <= SRC_NONE;
      r_cnt       <= '0;
      r_alu_stall <= 1'b0;
    end else begin
      r_in_reset  <= 1'b0;
      r_we        <= w_we_next;
      r_waddr     <= w_waddr_next;
      r_wdata     <= w_wdata_next;
      r_src       <= w_src_next;
      r_cnt       <= w_cnt_next;
      r_alu_stall <= (w_cnt_next == CW'(STARVE_MAX));
    end
  end

  // ALU results are forwarded by the pipeline, so only load/debug writes
  // sitting in the output stage count as hazards.
  assign w_out_match = r_we && ((r_src == SRC_LD) || (r_src == SRC_DBG)) &&
                       (((chk_addr_a != w_zero) && (chk_addr_a == r_waddr)) ||
                        ((chk_addr_b != w_zero) && (chk_addr_b == r_waddr)));

  assign stall_rd  = w_match || w_out_match;
  assign alu_stall = r_alu_stall;
  assign rf_we     = r_we;
  assign rf_waddr  = r_waddr;
  assign rf_wdata  = r_wdata;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed, table-driven bench for regfile_wb_arbiter: one row per clock
// cycle, plus a hand-written mid-operation reset sequence.
module tb_regfile_wb_arbiter;

  logic        clk;
  logic        rst_n;
  logic        alu_we;
  logic [4:0]  alu_addr;
  logic [31:0] alu_data;
  logic        alu_stall;
  logic        ld_valid;
  logic        ld_ready;
  logic [4:0]  ld_addr;
  logic [31:0] ld_data;
  logic        dbg_valid;
  logic        dbg_ready;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_data;
  logic [4:0]  chk_addr_a;
  logic [4:0]  chk_addr_b;
  logic        stall_rd;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  int n_pass;
  int n_total;

  regfile_wb_arbiter #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (5),
    .FIFO_DEPTH (2),
    .STARVE_MAX (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .alu_we     (alu_we),
    .alu_addr   (alu_addr),
    .alu_data   (alu_data),
    .alu_stall  (alu_stall),
    .ld_valid   (ld_valid),
    .ld_ready   (ld_ready),
    .ld_addr    (ld_addr),
    .ld_data    (ld_data),
    .dbg_valid  (dbg_valid),
    .dbg_ready  (dbg_ready),
    .dbg_addr   (dbg_addr),
    .dbg_data   (dbg_data),
    .chk_addr_a (chk_addr_a),
    .chk_addr_b (chk_addr_b),
    .stall_rd   (stall_rd),
    .rf_we      (rf_we),
    .rf_waddr   (rf_waddr),
    .rf_wdata   (rf_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        alu_we;
    logic [4:0]  alu_addr;
    logic [31:0] alu_data;
    logic        ld_valid;
    logic [4:0]  ld_addr;
    logic [31:0] ld_data;
    logic        dbg_valid;
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_data;
    logic [4:0]  chk_a;
    logic [4:0]  chk_b;
    logic        e_ld_ready;
    logic        e_dbg_ready;
    logic        e_stall_rd;
    logic        e_we;
    logic [4:0]  e_waddr;
    logic [31:0] e_wdata;
    logic        e_alu_stall;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    input logic aw, input logic [4:0] aa, input logic [31:0] ad,
    input logic lv, input logic [4:0] la, input logic [31:0] ld,
    input logic dv, input logic [4:0] da, input logic [31:0] dd,
    input logic [4:0] ca, input logic [4:0] cb,
    input logic elr, input logic edr, input logic esr,
    input logic ewe, input logic [4:0] ewa, input logic [31:0] ewd,
    input logic eas);
    vec_t v;
    v.alu_we = aw;  v.alu_addr = aa; v.alu_data = ad;
    v.ld_valid = lv; v.ld_addr = la; v.ld_data = ld;
    v.dbg_valid = dv; v.dbg_addr = da; v.dbg_data = dd;
    v.chk_a = ca; v.chk_b = cb;
    v.e_ld_ready = elr; v.e_dbg_ready = edr; v.e_stall_rd = esr;
    v.e_we = ewe; v.e_waddr = ewa; v.e_wdata = ewd; v.e_alu_stall = eas;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic drive(input vec_t v);
    alu_we = v.alu_we;     alu_addr = v.alu_addr; alu_data = v.alu_data;
    ld_valid = v.ld_valid; ld_addr = v.ld_addr;   ld_data = v.ld_data;
    dbg_valid = v.dbg_valid; dbg_addr = v.dbg_addr; dbg_data = v.dbg_data;
    chk_addr_a = v.chk_a;  chk_addr_b = v.chk_b;
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    rst_n = 1'b0;
    drive(mk(0,0,0, 0,0,0, 0,0,0, 0,0, 0,0,0, 0,0,0, 0));

    //          alu           ld              dbg           chk    lr dr sr we wa wd        as
    // ALU basic latency, in_reset gating of ld_ready
    vecs.push_back(mk(1,5,32'h1234, 0,0,0, 0,0,0, 0,0,  0,0,0, 1,5,32'h1234, 0));
    vecs.push_back(mk(0,0,0, 0,0,0, 0,0,0, 0,0,         1,1,0, 0,0,0, 0));
    // load to r7 buffered behind three ALU writes
    vecs.push_back(mk(1,1,32'h11, 1,7,32'hBEEF, 0,0,0, 7,0, 1,0,0, 1,1,32'h11, 0));
    vecs.push_back(mk(1,2,32'h22, 0,0,0, 0,0,0, 7,0,    1,0,1, 1,2,32'h22, 0));
    vecs.push_back(mk(1,3,32'h33, 0,0,0, 0,0,0, 7,0,    1,0,1, 1,3,32'h33, 0));
    vecs.push_back(mk(0,0,0, 0,0,0, 0,0,0, 7,0,         1,0,1, 1,7,32'hBEEF, 0));
    vecs.push_back(mk(0,0,0, 0,0,0, 0,0,0, 7,0,         1,1,1, 0,0,0, 0));
    vecs.push_back(mk(0,0,0, 0,0,0, 0,0,0, 7,0,         1,1,0, 0,0,0, 0));
    // fill the queue, third load held until the first drain
    vecs.push_back(mk(1,4,32'h44, 1,10,32'hA0, 0,0,0, 0,0, 1,0,0, 1,4,32'h44, 0));
    vecs.push_back(mk(1,4,32'h45, 1,11,32'hB0, 0,0,0, 0,0, 1,0,0, 1,4,32'h45, 0));
    vecs.push_back(mk(1,4,32'h46, 1,12,32'hC0, 0,0,0, 0,0, 0,0,0, 1,4,32'h46, 0));
    vecs.push_back(mk(0,0,0, 1,12,32'hC0, 0,0,0, 0,0,   0,0,0, 1,10,32'hA0, 0));
    vecs.push_back(mk(0,0,0, 1,12,32'hC0, 0,0,0, 0,0,   1,0,0, 1,11,32'hB0, 0));
    vecs.push_back(mk(0,0,0, 0,0,0, 0,0,0, 0,0,         1,0,0, 1,12,32'hC0, 0));
    vecs.push_back(mk(0,0,0, 0,0,0, 0,0,0, 0,0,         1,1,0, 0,0,0, 0));
    // squash of a buffered load to r9
    vecs.push_back(mk(0,0,0, 1,9,32'h99, 0,0,0, 9,0,    1,0,0, 0,0,0, 0));
    vecs.push_back(mk(1,9,32'h900, 0,0,0, 0,0,0, 9,0,   1,0,1, 1,9,32'h900, 0));
    vecs.push_back(mk(0,0,0, 0,0,0, 0,0,0, 9,0,         1,0,0, 0,0,0, 0));
    vecs.push_back(mk(0,0,0, 0,0,0, 0,0,0, 9,0,         1,1,0, 0,0,0, 0));
    // squash of a load enqueued in the same cycle as the ALU write
    vecs.push_back(mk(1,13,32'hD, 1,13,32'hE, 0,0,0, 0,13, 1,0,0, 1,13,32'hD, 0));
    vecs.push_back(mk(0,0,0, 0,0,0, 0,0,0, 0,13,        1,0,0, 0,0,0, 0));
    vecs.push_back(mk(0,0,0, 0,0,0, 0,0,0, 0,0,         1,1,0, 0,0,0, 0));
    // starvation: alu_stall after four blocked cycles, saturates, clears on drain
    vecs.push_back(mk(1,1,32'h1, 1,14,32'hEE, 0,0,0, 0,0, 1,0,0, 1,1,32'h1, 0));
    vecs.push_back(mk(1,1,32'h2, 0,0,0, 0,0,0, 0,0,     1,0,0, 1,1,32'h2, 0));
    vecs.push_back(mk(1,1,32'h3, 0,0,0, 0,0,0, 0,0,     1,0,0, 1,1,32'h3, 0));
    vecs.push_back(mk(1,1,32'h4, 0,0,0, 0,0,0, 0,0,     1,0,0, 1,1,32'h4, 0));
    vecs.push_back(mk(1,1,32'h5, 0,0,0, 0,0,0, 0,0,     1,0,0, 1,1,32'h5, 1));
    vecs.push_back(mk(1,1,32'h6, 0,0,0, 0,0,0, 0,0,     1,0,0, 1,1,32'h6, 1));
    vecs.push_back(mk(0,0,0, 0,0,0, 0,0,0, 0,0,         1,0,0, 1,14,32'hEE, 0));
    vecs.push_back(mk(0,0,0, 0,0,0, 0,0,0, 0,0,         1,1,0, 0,0,0, 0));
    // debug write held off by a non-empty queue and a busy ALU
    vecs.push_back(mk(0,0,0, 1,15,32'hF0, 0,0,0, 0,0,   1,0,0, 0,0,0, 0));
    vecs.push_back(mk(1,2,32'h2, 0,0,0, 1,3,32'h333, 3,0, 1,0,0, 1,2,32'h2, 0));
    vecs.push_back(mk(0,0,0, 0,0,0, 1,3,32'h333, 3,0,   1,0,0, 1,15,32'hF0, 0));
    vecs.push_back(mk(0,0,0, 0,0,0, 1,3,32'h333, 3,0,   1,1,0, 1,3,32'h333, 0));
    vecs.push_back(mk(0,0,0, 0,0,0, 0,0,0, 3,0,         1,1,1, 0,0,0, 0));
    // register 0 is never written from any source
    vecs.push_back(mk(1,0,32'hFF, 0,0,0, 0,0,0, 0,0,    1,0,0, 0,0,0, 0));
    vecs.push_back(mk(0,0,0, 1,0,32'h5, 0,0,0, 0,0,     1,0,0, 0,0,0, 0));
    vecs.push_back(mk(0,0,0, 0,0,0, 1,0,32'h77, 0,0,    1,1,0, 0,0,0, 0));
    vecs.push_back(mk(0,0,0, 0,0,0, 0,0,0, 0,0,         1,1,0, 0,0,0, 0));

    repeat (2) @(posedge clk);
    #1;
    check("rst_rf_we", 32'(rf_we), 0);
    check("rst_rf_waddr", 32'(rf_waddr), 0);
    check("rst_rf_wdata", rf_wdata, 0);
    check("rst_alu_stall", 32'(alu_stall), 0);
    check("rst_ld_ready", 32'(ld_ready), 0);
    check("rst_dbg_ready", 32'(dbg_ready), 0);
    check("rst_stall_rd", 32'(stall_rd), 0);
    rst_n = 1'b1;

    foreach (vecs[k]) begin
      drive(vecs[k]);
      #1;
      check($sformatf("v%0d_ld_ready", k), 32'(ld_ready), 32'(vecs[k].e_ld_ready));
      check($sformatf("v%0d_dbg_ready", k), 32'(dbg_ready), 32'(vecs[k].e_dbg_ready));
      check($sformatf("v%0d_stall_rd", k), 32'(stall_rd), 32'(vecs[k].e_stall_rd));
      @(posedge clk);
      #1;
      check($sformatf("v%0d_rf_we", k), 32'(rf_we), 32'(vecs[k].e_we));
      check($sformatf("v%0d_alu_stall", k), 32'(alu_stall), 32'(vecs[k].e_alu_stall));
      if (vecs[k].e_we) begin
        check($sformatf("v%0d_rf_waddr", k), 32'(rf_waddr), 32'(vecs[k].e_waddr));
        check($sformatf("v%0d_rf_wdata", k), rf_wdata, vecs[k].e_wdata);
      end
    end

    // reset mid-operation discards the queue and the pending output write
    drive(mk(1,6,32'h66, 1,8,32'h88, 0,0,0, 0,0, 0,0,0, 0,0,0, 0));
    @(posedge clk);
    #1;
    check("mr_pre_rf_we", 32'(rf_we), 1);
    drive(mk(0,0,0, 0,0,0, 0,0,0, 8,0, 0,0,0, 0,0,0, 0));
    #1;
    check("mr_pre_stall_rd", 32'(stall_rd), 1);
    rst_n = 1'b0;
    #1;
    check("mr_rf_we", 32'(rf_we), 0);
    check("mr_rf_waddr", 32'(rf_waddr), 0);
    check("mr_ld_ready", 32'(ld_ready), 0);
    check("mr_stall_rd", 32'(stall_rd), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check("mr_inreset_ld_ready", 32'(ld_ready), 0);
    check("mr_inreset_dbg_ready", 32'(dbg_ready), 0);
    @(posedge clk);
    #1;
    check("mr_post_rf_we", 32'(rf_we), 0);
    check("mr_post_ld_ready", 32'(ld_ready), 1);
    check("mr_post_dbg_ready", 32'(dbg_ready), 1);
    @(posedge clk);
    #1;
    check("mr_post2_rf_we", 32'(rf_we), 0);
    check("mr_post2_stall_rd", 32'(stall_rd), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-port controller for the MIPS dual-read/single-write register file. It shares the single write port between three producers: the ALU writeback stage, the load-return unit and the debug host. It buffers load returns in a small queue and raises a read-hazard stall for registers with writes still pending. It sits between the execute/memory stages and the register file's write inputs (we_en, WrAddr, WrDta).

## Interface
- DATA_WIDTH, 32, register width
- ADDR_WIDTH, 5, register index width
- FIFO_DEPTH, 2, load-return queue entries (power of two, ≥2)
- STARVE_MAX, 4, consecutive blocked-drain cycles before alu_stall

Ports:
- clk  in  1  rising-edge clock; the only clock
- rst_n  in  1  asynchronous, active-low reset
- alu_we  in  1  ALU writeback valid; no handshake, always accepted
- alu_addr  in  ADDR_WIDTH  ALU destination
- alu_data  in  DATA_WIDTH  ALU result
- alu_stall  out  1  advisory request to the pipeline to idle ALU writeback
- ld_valid  in  1  load-return valid
- ld_ready  out  1  load-return ready
- ld_addr  in  ADDR_WIDTH  load destination
- ld_data  in  DATA_WIDTH  load data
- dbg_valid  in  1  debug write valid
- dbg_ready  out  1  debug write ready
- dbg_addr  in  ADDR_WIDTH  debug destination
- dbg_data  in  DATA_WIDTH  debug data
- chk_addr_a, chk_addr_b  in  ADDR_WIDTH  decode-stage source registers
- stall_rd  out  1  a source register has a pending load or debug write
- rf_we, rf_waddr, rf_wdata  out  1/ADDR_WIDTH/DATA_WIDTH  drive register-file we_en/WrAddr/WrDta

## Operation
- Priority on the write port: ALU > FIFO head > debug.
- ALU: when alu_we=1 and alu_addr≠0, the output stage loads {1, alu_addr, alu_data}.
- Load: accepted when ld_valid && ld_ready, with ld_ready = !full && !in_reset.
  - Accepted entries go to the FIFO tail with a live bit set.
  - ld_addr=0 is accepted but not enqueued.
- Drain: when alu_we=0 and the head is live, the head pops into the output stage.
  - A non-live head pops in any cycle, even when alu_we=1, and produces no write.
- Debug: dbg_ready = !alu_we && FIFO empty && !ld_valid && !in_reset.
  - An accepted debug write with dbg_addr≠0 loads the output stage.
- Any cycle with no winner loads rf_we=0.
- Squash: an ALU write to address X clears the live bit of every FIFO entry with address X. This includes an entry enqueued in the same cycle; the ALU write counts as newer.
- Starvation counter:
  - Increments each cycle the FIFO head is live and alu_we=1.
  - Clears on any drain or when the FIFO is empty.
  - Saturates at STARVE_MAX.
  - alu_stall = (count == STARVE_MAX), registered.
  - alu_stall is advisory: if alu_we is still high, the ALU still wins.
- stall_rd (combinational): asserted when chk_addr_a or chk_addr_b (≠0) equals the address of any live FIFO entry, or equals rf_waddr while rf_we=1 and the output-stage source is load or debug.
- in_reset flop: set by reset, clears on the first clk edge after rst_n rises.

## Timing
- Reset values:
  - rf_we=0, rf_waddr=0, rf_wdata=0, alu_stall=0
  - FIFO empty, all live bits 0, starvation count 0
  - ld_ready=0, dbg_ready=0, stall_rd=0
- Reset asserted mid-operation discards the FIFO contents and any pending output-stage write immediately.
- Latency:
  - ALU: alu_we in cycle N gives rf_we in cycle N+1.
  - Load: accepted in cycle N gives rf_we no earlier than N+2, and only if alu_we=0 in N+1.
  - Debug: accepted in N gives rf_we in N+1.
- FIFO full: ld_ready=0 the same cycle. Pop and push in the same cycle are allowed; the pop frees the slot only from the next cycle.
- Pointers wrap modulo FIFO_DEPTH; full/empty use an extra pointer bit.

## Structure
- regfile_pkg holds DATA_WIDTH/ADDR_WIDTH defaults, REG_ZERO=0 and the wb_src_t enum {SRC_NONE, SRC_ALU, SRC_LD, SRC_DBG} for the output-stage source tag.
- Sub-module regfile_wb_fifo: queue with a per-entry live bit, a squash-by-address port and a match-by-address port (two compare addresses).

## Test plan
- Reset, then alu_we=1, alu_addr=5, alu_data=0x1234 -> next cycle rf_we=1, rf_waddr=5, rf_wdata=0x1234; ld_ready goes 1 one cycle after rst_n rises.
- Load to register 7 (0xBEEF) accepted while alu_we=1 for 3 cycles -> stall_rd=1 for chk_addr_a=7 throughout; write of 0xBEEF to register 7 in the 2nd cycle after alu_we drops.
- Two loads accepted while the ALU is busy -> ld_ready=0; a third ld_valid is held until the first drain.
- Load to register 9 buffered, then ALU writes register 9 -> entry squashed; no rf_we for the load; stall_rd for register 9 clears.
- alu_we held high with a live head -> alu_stall=1 after 4 cycles; clears once alu_we=0 lets the head drain.
- dbg_valid to register 3 with the FIFO non-empty -> dbg_ready=0 until the FIFO is empty and alu_we=0; writes to register 0 from any source never produce rf_we.
